mm_game_ctrl: RTL and testbench

Turn sequencer for the mastermind game. It latches a secret code from the PRNG and accepts a committed guess on a select press. It scores the guess over several cycles (exact and colour-only matches), then advances the turn, declares a win, or declares a loss. It sits between the debounced buttons/guess editor and the history, feedback and turn-LED blocks, and drives their write/clear strobes.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_game_ctrl_if.sv | 32 +++
 rtl/mm_color_count.sv | 20 ++
 rtl/mm_game_ctrl.sv | 142 ++++++++++++++
 tb/tb_mm_game_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types, constants and helpers for the mastermind turn sequencer
package mm_pkg;

  localparam int NUM_PEGS = 4;
  localparam int COLOR_W  = 3;

  typedef logic [NUM_PEGS*COLOR_W-1:0] peg_code_t;

  typedef enum logic [2:0] {
    LATCH = 3'd0,
    GUESS = 3'd1,
    SCORE = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  // Smaller of two peg counts; the per-colour contribution to the total match count
  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mm_game_ctrl_if.sv
// rtl/mm_game_ctrl_if.sv - button/code inputs and history/feedback outputs of the turn sequencer
interface mm_game_ctrl_if #(
  parameter int COLOR_W = 3,
  parameter int TURN_W  = 4
);
  logic                 mode_i;
  logic                 select_i;
  logic [4*COLOR_W-1:0] code_i;
  logic [4*COLOR_W-1:0] guess_i;
  logic                 hist_we_o;
  logic                 hist_clr_o;
  logic [TURN_W-1:0]    turn_o;
  logic [2:0]           exact_o;
  logic [2:0]           partial_o;
  logic                 score_vld_o;
  logic                 busy_o;
  logic                 win_o;
  logic                 lose_o;
  logic [4*COLOR_W-1:0] secret_o;

  modport master (
    output mode_i, select_i, code_i, guess_i,
    input  hist_we_o, hist_clr_o, turn_o, exact_o, partial_o,
    input  score_vld_o, busy_o, win_o, lose_o, secret_o
  );

  modport slave (
    input  mode_i, select_i, code_i, guess_i,
    output hist_we_o, hist_clr_o, turn_o, exact_o, partial_o,
    output score_vld_o, busy_o, win_o, lose_o, secret_o
  );
endinterface

// File: rtl/mm_color_count.sv
// rtl/mm_color_count.sv - number of pegs in a 4-peg code that carry a given colour
module mm_color_count
  import mm_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic [NUM_PEGS*CW-1:0] code,
  input  logic [CW-1:0]          color,
  output logic [2:0]             count
);

  // Popcount of peg == color across the four pegs
  always_comb begin
    count = 3'd0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (code[i*CW +: CW] == color) count = count + 3'd1;
    end
  end

endmodule

// File: rtl/mm_game_ctrl.sv
// rtl/mm_game_ctrl.sv - mastermind turn sequencer; MM_REVEAL_ON_LOSE_EN shows the secret after a loss
module mm_game_ctrl
  import mm_pkg::*;
#(
  parameter int MAX_TURNS = 8,
  parameter int COLOR_W   = 3,
  parameter int TURN_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mm_game_ctrl_if.slave      bus
);

  localparam int CODE_W = NUM_PEGS * COLOR_W;

  state_t              state;
  logic                sel_q;
  logic [CODE_W-1:0]   secret_q;
  logic [CODE_W-1:0]   guess_q;
  logic [COLOR_W-1:0]  color_q;
  logic [2:0]          acc_q;
  logic [2:0]          exact_q;
  logic [2:0]          exact_c;
  logic [2:0]          cnt_secret;
  logic [2:0]          cnt_guess;
  logic [TURN_W-1:0]   turn_nxt;
  logic                press;
  logic                accept;

  assign press    = bus.select_i & ~sel_q;
  assign accept   = press & (((state == GUESS) & ~bus.mode_i) | (state == WIN) | (state == LOSE));
  assign turn_nxt = bus.turn_o + TURN_W'(1);

  mm_color_count #(.CW(COLOR_W)) u_cnt_secret (
    .code  (secret_q),
    .color (color_q),
    .count (cnt_secret)
  );

  mm_color_count #(.CW(COLOR_W)) u_cnt_guess (
    .code  (guess_q),
    .color (color_q),
    .count (cnt_guess)
  );

  // Pegs matching in both colour and position
  always_comb begin
    exact_c = 3'd0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (secret_q[i*COLOR_W +: COLOR_W] == guess_q[i*COLOR_W +: COLOR_W]) exact_c = exact_c + 3'd1;
    end
  end

  // Game sequencer: latch secret, take guess, sweep colours, then judge the turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= LATCH;
      sel_q            <= 1'b1;
      secret_q         <= '0;
      guess_q          <= '0;
      color_q          <= '0;
      acc_q            <= 3'd0;
      exact_q          <= 3'd0;
      bus.hist_we_o    <= 1'b0;
      bus.hist_clr_o   <= 1'b0;
      bus.turn_o       <= '0;
      bus.exact_o      <= 3'd0;
      bus.partial_o    <= 3'd0;
      bus.score_vld_o  <= 1'b0;
      bus.busy_o       <= 1'b1;
      bus.win_o        <= 1'b0;
      bus.lose_o       <= 1'b0;
    end else begin
      sel_q           <= bus.select_i;
      bus.hist_we_o   <= 1'b0;
      bus.hist_clr_o  <= 1'b0;
      bus.score_vld_o <= 1'b0;
      case (state)
        LATCH: begin
          secret_q       <= bus.code_i;
          bus.hist_clr_o <= 1'b1;
          bus.turn_o     <= '0;
          bus.exact_o    <= 3'd0;
          bus.partial_o  <= 3'd0;
          bus.busy_o     <= 1'b0;
          state          <= GUESS;
        end
        GUESS: begin
          if (accept) begin
            guess_q       <= bus.guess_i;
            bus.hist_we_o <= 1'b1;
            color_q       <= '0;
            acc_q         <= 3'd0;
            bus.busy_o    <= 1'b1;
            state         <= SCORE;
          end
        end
        SCORE: begin
          if (color_q == '0) exact_q <= exact_c;
          acc_q   <= acc_q + min3(cnt_secret, cnt_guess);
          color_q <= color_q + COLOR_W'(1);
          if (color_q == {COLOR_W{1'b1}}) begin
            bus.busy_o <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          bus.exact_o     <= exact_q;
          bus.partial_o   <= acc_q - exact_q;
          bus.score_vld_o <= 1'b1;
          bus.turn_o      <= turn_nxt;
          if (exact_q == 3'd4) begin
            bus.win_o <= 1'b1;
            state     <= WIN;
          end else if (turn_nxt == TURN_W'(MAX_TURNS)) begin
            bus.lose_o <= 1'b1;
            state      <= LOSE;
          end else begin
            state <= GUESS;
          end
        end
        WIN, LOSE: begin
          if (accept) begin
            bus.win_o  <= 1'b0;
            bus.lose_o <= 1'b0;
            bus.busy_o <= 1'b1;
            state      <= LATCH;
          end
        end
        default: state <= LATCH;
      endcase
    end
  end

`ifdef MM_REVEAL_ON_LOSE_EN
  // Expose the secret only once the game is lost
  assign bus.secret_o = bus.lose_o ? secret_q : '0;
`else
  assign bus.secret_o = '0;
`endif

endmodule

// File: tb/tb_mm_game_ctrl.sv
// tb/tb_mm_game_ctrl.sv - directed scoreboard bench for mm_game_ctrl
module tb_mm_game_ctrl;

  typedef struct {
    logic [2:0] e;
    logic [2:0] p;
    logic [3:0] t;
    logic       w;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   clr_cnt = 0;
  exp_t exp_q[$];

  mm_game_ctrl_if #(.COLOR_W(3), .TURN_W(4)) bus ();

  mm_game_ctrl #(.MAX_TURNS(8), .COLOR_W(3), .TURN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pegs(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard whenever a score is published
  always @(negedge clk) begin
    exp_t e;
    if (bus.hist_we_o) we_cnt++;
    if (bus.hist_clr_o) clr_cnt++;
    if (bus.score_vld_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_score_vld", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("exact", 32'(bus.exact_o), 32'(e.e));
        chk("partial", 32'(bus.partial_o), 32'(e.p));
        chk("turn", 32'(bus.turn_o), 32'(e.t));
        chk("win", 32'(bus.win_o), 32'(e.w));
        chk("lose", 32'(bus.lose_o), 32'(e.l));
      end
    end
  end

  // opt bit0: extra press during SCORE; bit1: mode_i raised during SCORE
  task automatic do_guess(input logic [11:0] g, input int e, input int p, input int t,
                          input bit w, input bit l, input int opt);
    exp_t x;
    int   k;
    int   we0;
    bit   got;
    @(negedge clk);
    x.e = 3'(e); x.p = 3'(p); x.t = 4'(t); x.w = w; x.l = l;
    exp_q.push_back(x);
    we0 = we_cnt;
    bus.guess_i = g;
    bus.select_i = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 30 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        chk("hist_we_on_press", 32'(bus.hist_we_o), 32'd1);
        chk("hist_we_turn", 32'(bus.turn_o), 32'(t - 1));
        chk("busy_in_score", 32'(bus.busy_o), 32'd1);
      end
      if (k == 3) begin
        bus.guess_i = 12'($urandom);
        bus.code_i  = 12'($urandom);
        if (opt[0]) bus.select_i = 1'b0;
        if (opt[1]) bus.mode_i = 1'b1;
      end
      if (k == 5 && opt[0]) bus.select_i = 1'b1;
      if (bus.score_vld_o) got = 1'b1;
    end
    chk("latency", 32'(k), 32'd10);
    @(negedge clk);
    bus.select_i = 1'b0;
    bus.mode_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("one_hist_we_per_guess", 32'(we_cnt), 32'(we0 + 1));
  endtask

  task automatic restart();
    @(negedge clk);
    bus.select_i = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_levels_clear", 32'({bus.win_o, bus.lose_o}), 32'd0);
    @(posedge clk);
    #1;
    chk("restart_hist_clr", 32'(bus.hist_clr_o), 32'd1);
    chk("restart_turn", 32'(bus.turn_o), 32'd0);
    chk("restart_exact", 32'(bus.exact_o), 32'd0);
    @(negedge clk);
    bus.select_i = 1'b0;
  endtask

  initial begin
    logic [11:0] sec1;
    int we0;
    sec1 = pegs(1, 2, 3, 4);
    rst_n = 1'b0;
    bus.mode_i = 1'b0;
    bus.select_i = 1'b1;
    bus.code_i = sec1;
    bus.guess_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_turn", 32'(bus.turn_o), 32'd0);
    chk("rst_exact_partial", 32'({bus.exact_o, bus.partial_o}), 32'd0);
    chk("rst_strobes", 32'({bus.hist_we_o, bus.hist_clr_o, bus.score_vld_o}), 32'd0);
    chk("rst_win_lose", 32'({bus.win_o, bus.lose_o}), 32'd0);
    chk("rst_secret", 32'(bus.secret_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd1);

    // Release with select held: the latch happens, no press fires
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("latch_hist_clr", 32'(bus.hist_clr_o), 32'd1);
    chk("latch_busy_low", 32'(bus.busy_o), 32'd0);
    bus.code_i = pegs(7, 7, 7, 7);
    repeat (4) @(posedge clk);
    #1;
    chk("held_select_no_we", 32'(we_cnt), 32'd0);
    chk("clr_pulse_once", 32'(clr_cnt), 32'd1);
    @(negedge clk);
    bus.select_i = 1'b0;

    // Game 1: eight wrong guesses against secret (1,2,3,4)
    do_guess(pegs(4, 3, 2, 1), 0, 4, 1, 0, 0, 0);
    do_guess(pegs(1, 2, 4, 3), 2, 2, 2, 0, 0, 1);

    // Browse mode blocks presses in GUESS
    bus.mode_i = 1'b1;
    we0 = we_cnt;
    repeat (3) begin
      @(negedge clk); bus.select_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.select_i = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("mode_blocks_we", 32'(we_cnt), 32'(we0));
    chk("mode_blocks_turn", 32'(bus.turn_o), 32'd2);
    bus.mode_i = 1'b0;

    do_guess(pegs(0, 0, 0, 0), 0, 0, 3, 0, 0, 0);
    do_guess(pegs(1, 1, 1, 1), 1, 0, 4, 0, 0, 2);
    do_guess(pegs(2, 1, 7, 7), 0, 2, 5, 0, 0, 0);
    do_guess(pegs(1, 2, 3, 5), 3, 0, 6, 0, 0, 1);
    do_guess(pegs(4, 4, 4, 4), 1, 0, 7, 0, 0, 0);
    chk("secret_hidden_before_loss", 32'(bus.secret_o), 32'd0);
    do_guess(pegs(3, 4, 1, 2), 0, 4, 8, 0, 1, 0);
    chk("lose_level", 32'(bus.lose_o), 32'd1);
`ifdef MM_REVEAL_ON_LOSE_EN
    chk("secret_reveal", 32'(bus.secret_o), 32'(sec1));
`else
    chk("secret_tied_zero", 32'(bus.secret_o), 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("lose_holds_turn", 32'(bus.turn_o), 32'd8);

    // Game 2: restart from LOSE in browse mode
    bus.code_i = pegs(1, 1, 2, 2);
    bus.mode_i = 1'b1;
    restart();
    bus.mode_i = 1'b0;
    do_guess(pegs(1, 2, 1, 5), 1, 2, 1, 0, 0, 0);

    // Reset mid-SCORE discards the guess
    @(negedge clk);
    bus.guess_i = pegs(1, 1, 2, 2);
    bus.select_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.code_i = pegs(5, 5, 5, 5);
    #1;
    chk("midscore_rst_vld", 32'(bus.score_vld_o), 32'd0);
    chk("midscore_rst_turn", 32'(bus.turn_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("relatch_hist_clr", 32'(bus.hist_clr_o), 32'd1);
    repeat (15) @(negedge clk);
    bus.select_i = 1'b0;

    // Game 3: immediate win, then restart
    do_guess(pegs(5, 5, 5, 5), 4, 0, 1, 1, 0, 0);
    chk("win_level", 32'(bus.win_o), 32'd1);
    chk("win_secret_zero", 32'(bus.secret_o), 32'd0);
    restart();

    repeat (5) @(negedge clk);
    chk("total_hist_clr", 32'(clr_cnt), 32'd4);
    chk("total_hist_we", 32'(we_cnt), 32'd11);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
